// File: rtl/tri_projector.sv
// Camera-to-screen triangle projector: near-plane cull, shared 64/32 restoring divider, viewport offset.
// Optional back-face culling stage is built when TRI_PROJECTOR_BACKFACE_CULL_EN is defined.
module tri_projector #(
  parameter int                 WIDTH  = 360,
  parameter int                 HEIGHT = 360,
  parameter int                 FOCAL  = 256,
  parameter logic signed [31:0] NEAR   = 32'sh0000_8000
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [2:0][2:0][31:0]  tri_in,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [3:0][2:0][31:0]  triangle_out,
  output logic                   valid_tri,
  input  logic                   out_ready,
  output logic                   obj_done,
  output logic                   busy,
  output logic [15:0]            cull_count
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DIV,
    ASSEMBLE,
`ifdef TRI_PROJECTOR_BACKFACE_CULL_EN
    CULL,
`endif
    OUT,
    DONE
  } state_t;

  localparam logic [31:0] X_CENTRE = 32'(WIDTH / 2) << 16;
  localparam logic [31:0] Y_CENTRE = 32'(HEIGHT / 2) << 16;
  localparam logic [63:0] Q_MAX    = 64'h0000_0000_3FFF_FFFF;

  state_t              state, state_nx;
  logic [2:0][2:0][31:0] tri_q;
  logic                last_q;
  logic [2:0]          job;
  logic [5:0]          iter;
  logic                setup;
  logic [63:0]         quo;
  logic [31:0]         rem;
  logic [2:0][31:0]    sx, sy;

  logic [31:0] coord, zdiv, abs_coord, q_sat, q_sgn, sx_new, sy_new;
  logic [63:0] dividend, quo_nx;
  logic [32:0] rem_sh;
  logic [31:0] rem_nx;
  logic        ge, last_step, near_hit, cull_hit;
  logic [15:0] cull_inc;

  // Job j selects vertex j/2, axis j%2 (x then y).
  assign coord     = tri_q[job[2:1]][job[0]];
  assign zdiv      = tri_q[job[2:1]][2];
  assign abs_coord = coord[31] ? (32'd0 - coord) : coord;
  assign dividend  = (64'(abs_coord) * 64'(FOCAL)) << 16;

  assign rem_sh = {rem, quo[63]};
  assign ge     = rem_sh >= {1'b0, zdiv};
  assign rem_nx = ge ? 32'(rem_sh - {1'b0, zdiv}) : rem_sh[31:0];
  assign quo_nx = {quo[62:0], ge};

  assign q_sat  = (quo_nx > Q_MAX) ? Q_MAX[31:0] : quo_nx[31:0];
  assign q_sgn  = coord[31] ? (32'd0 - q_sat) : q_sat;
  assign sx_new = X_CENTRE + q_sgn;
  assign sy_new = Y_CENTRE - q_sgn;

  assign last_step = !setup && (iter == 6'd63);
  assign near_hit  = ($signed(tri_q[0][2]) <= NEAR) ||
                     ($signed(tri_q[1][2]) <= NEAR) ||
                     ($signed(tri_q[2][2]) <= NEAR);
  assign cull_inc  = (cull_count == 16'hFFFF) ? cull_count : cull_count + 16'd1;

`ifdef TRI_PROJECTOR_BACKFACE_CULL_EN
  // Signed area on integer pixel parts; non-positive means back-facing or degenerate.
  logic signed [16:0] dx1, dy2, dx2, dy1;
  logic signed [33:0] prod_a, prod_b;
  logic signed [34:0] area;
  logic               area_pos;

  assign dx1      = {sx[1][31], sx[1][31:16]} - {sx[0][31], sx[0][31:16]};
  assign dy2      = {sy[2][31], sy[2][31:16]} - {sy[0][31], sy[0][31:16]};
  assign dx2      = {sx[2][31], sx[2][31:16]} - {sx[0][31], sx[0][31:16]};
  assign dy1      = {sy[1][31], sy[1][31:16]} - {sy[0][31], sy[0][31:16]};
  assign prod_a   = dx1 * dy2;
  assign prod_b   = dx2 * dy1;
  assign area     = {prod_a[33], prod_a} - {prod_b[33], prod_b};
  assign area_pos = !area[34] && (area != 35'sd0);
  assign cull_hit = ((state == LOAD) && near_hit) || ((state == CULL) && !area_pos);
`else
  assign cull_hit = (state == LOAD) && near_hit;
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    valid_tri = 1'b0;
    obj_done  = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nx = LOAD;
      end
      LOAD:     state_nx = near_hit ? DONE : DIV;
      DIV:      if (last_step && (job == 3'd5)) state_nx = ASSEMBLE;
`ifdef TRI_PROJECTOR_BACKFACE_CULL_EN
      ASSEMBLE: state_nx = CULL;
      CULL:     state_nx = area_pos ? OUT : DONE;
`else
      ASSEMBLE: state_nx = OUT;
`endif
      OUT: begin
        valid_tri = 1'b1;
        if (out_ready) state_nx = DONE;
      end
      DONE: begin
        obj_done = last_q;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      tri_q        <= '0;
      last_q       <= 1'b0;
      job          <= '0;
      iter         <= '0;
      setup        <= 1'b0;
      quo          <= '0;
      rem          <= '0;
      sx           <= '0;
      sy           <= '0;
      triangle_out <= '0;
      cull_count   <= '0;
    end else begin
      if (cull_hit) cull_count <= cull_inc;
      case (state)
        IDLE: begin
          if (in_valid) begin
            tri_q  <= tri_in;
            last_q <= in_last;
          end
        end
        LOAD: begin
          job   <= '0;
          setup <= 1'b1;
        end
        DIV: begin
          if (setup) begin
            quo   <= dividend;
            rem   <= '0;
            iter  <= '0;
            setup <= 1'b0;
          end else begin
            quo  <= quo_nx;
            rem  <= rem_nx;
            iter <= iter + 6'd1;
            if (last_step) begin
              if (job[0]) sy[job[2:1]] <= sy_new;
              else        sx[job[2:1]] <= sx_new;
              job   <= job + 3'd1;
              setup <= 1'b1;
            end
          end
        end
        ASSEMBLE: begin
          triangle_out[3] <= '0;
          for (int v = 0; v < 3; v++) begin
            triangle_out[2][v] <= sx[v];
            triangle_out[1][v] <= sy[v];
            triangle_out[0][v] <= tri_q[v][2];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tri_projector.sv
// Bench for tri_projector: directed corner cases plus randomized triangles against an arithmetic model.
module tb_tri_projector;
  typedef logic [2:0][2:0][31:0] tri_t;
  typedef logic [3:0][2:0][31:0] tout_t;

`ifdef TRI_PROJECTOR_BACKFACE_CULL_EN
  localparam int LAT = 393;
`else
  localparam int LAT = 392;
`endif

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  tri_t tri_in = '0;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic in_ready, valid_tri, obj_done, busy;
  tout_t triangle_out;
  logic [15:0] cull_count;

  tri_projector dut (
    .clk_in(clk_in), .rst_in(rst_in), .tri_in(tri_in), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .triangle_out(triangle_out),
    .valid_tri(valid_tri), .out_ready(out_ready), .obj_done(obj_done),
    .busy(busy), .cull_count(cull_count)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0, checks = 0;
  int exp_cull = 0, exp_done = 0, seen_done = 0;
  tout_t exp_q[$];
  tout_t held;
  bit held_vld = 0;
  bit rand_rdy = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: stability while stalled, pop-and-compare on each transfer.
  always @(negedge clk_in) begin
    if (rst_in) begin
      held_vld = 0;
    end else begin
      if (obj_done) seen_done++;
      if (valid_tri) begin
        if (held_vld) begin
          checks++;
          if (triangle_out !== held) begin
            errors++;
            $display("FAIL stall_stable got=%h expected=%h", triangle_out, held);
          end
        end
        if (out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_tri got=%h expected=none", triangle_out);
          end else begin
            tout_t e;
            e = exp_q.pop_front();
            if (triangle_out !== e) begin
              errors++;
              $display("FAIL tri_out got=%h expected=%h", triangle_out, e);
            end
          end
          held_vld = 0;
        end else begin
          held = triangle_out;
          held_vld = 1;
        end
      end
    end
  end

  always @(posedge clk_in) begin
    if (rand_rdy) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  function automatic logic [31:0] scr(input logic [31:0] c, input logic [31:0] z, input bit is_y);
    longint cs, mag, q, centre;
    cs = longint'($signed(c));
    mag = (cs < 0) ? -cs : cs;
    q = (mag * 256 * 65536) / longint'($signed(z));
    if (q > 64'sh3FFF_FFFF) q = 64'sh3FFF_FFFF;
    if (cs < 0) q = -q;
    centre = 180 * 65536;
    return is_y ? 32'(centre - q) : 32'(centre + q);
  endfunction

  function automatic void model(input tri_t t, output tout_t e, output bit near, output bit back);
    longint px[3], py[3], area;
    e = '0;
    near = 0;
    for (int v = 0; v < 3; v++) begin
      if ($signed(t[v][2]) <= $signed(32'h0000_8000)) near = 1;
    end
    for (int v = 0; v < 3; v++) begin
      if (!near) begin
        e[2][v] = scr(t[v][0], t[v][2], 0);
        e[1][v] = scr(t[v][1], t[v][2], 1);
      end
      e[0][v] = t[v][2];
      px[v] = longint'($signed(e[2][v][31:16]));
      py[v] = longint'($signed(e[1][v][31:16]));
    end
    area = (px[1] - px[0]) * (py[2] - py[0]) - (px[2] - px[0]) * (py[1] - py[0]);
`ifdef TRI_PROJECTOR_BACKFACE_CULL_EN
    back = !near && (area <= 0);
`else
    back = 0;
`endif
  endfunction

  task automatic accept(input tri_t t, input bit last);
    int n;
    @(negedge clk_in);
    tri_in = t;
    in_last = last;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 3000) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= 3000) begin
      errors++;
      $display("FAIL accept_timeout got=busy expected=in_ready");
    end
    @(posedge clk_in);
    #1 in_valid = 1'b0;
  endtask

  task automatic issue(input tri_t t, input bit last, input bit use_ovr, input tout_t ovr);
    tout_t e;
    bit near, back;
    model(t, e, near, back);
    if (near || back) exp_cull++;
    else exp_q.push_back(use_ovr ? ovr : e);
    if (last) exp_done++;
    accept(t, last);
  endtask

  task automatic finish_tri(input string name);
    int n = 0;
    @(negedge clk_in);
    while (!in_ready && n < 3000) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= 3000) begin
      errors++;
      $display("FAIL %s_idle_timeout got=busy expected=idle", name);
    end
    check({name, "_cull"}, 64'(cull_count), 64'(exp_cull));
  endtask

  task automatic wait_valid(output int edges);
    edges = 0;
    do begin
      @(posedge clk_in);
      edges++;
      @(negedge clk_in);
    end while (!valid_tri && edges < 600);
  endtask

  function automatic logic [31:0] q16(input int i);
    return 32'(i) << 16;
  endfunction

  initial begin
    tri_t base, swp, nearc, sat, rt;
    tout_t base_e, sat_e, none;
    bit n_, b_;
    int edges;
    none = '0;

    base[0][0] = 0;       base[0][1] = 0;       base[0][2] = q16(2);
    base[1][0] = -q16(1); base[1][1] = 0;       base[1][2] = q16(4);
    base[2][0] = q16(1);  base[2][1] = q16(1);  base[2][2] = q16(2);
    base_e = '0;
    base_e[2][0] = 32'h00B4_0000; base_e[2][1] = 32'h0074_0000; base_e[2][2] = 32'h0134_0000;
    base_e[1][0] = 32'h00B4_0000; base_e[1][1] = 32'h00B4_0000; base_e[1][2] = 32'h0034_0000;
    base_e[0][0] = q16(2); base_e[0][1] = q16(4); base_e[0][2] = q16(2);

    // Reset state
    #1;
    check("rst_valid", 64'(valid_tri), 0);
    check("rst_ready", 64'(in_ready), 1);
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(obj_done), 0);
    check("rst_tri", 64'(triangle_out[2][0] | triangle_out[1][2] | triangle_out[0][1]), 0);
    check("rst_cull", 64'(cull_count), 0);
    repeat (3) @(posedge clk_in);
    @(negedge clk_in) rst_in = 1'b0;

    // Near cull of a last triangle: DONE two cycles after the accept cycle
    nearc = base;
    nearc[1][2] = 32'h0000_4000;
    issue(nearc, 1, 0, none);
    @(posedge clk_in); @(negedge clk_in);
    check("near_done_pulse", 64'(obj_done), 1);
    check("near_no_valid", 64'(valid_tri), 0);
    @(posedge clk_in); @(negedge clk_in);
    check("near_done_single", 64'(obj_done), 0);
    check("near_ready_back", 64'(in_ready), 1);
    finish_tri("near");

    // Reset in the middle of the divide
    accept(base, 1);
    repeat (99) @(posedge clk_in);
    #2 rst_in = 1'b1;
    #1;
    exp_cull = 0;
    check("mid_rst_valid", 64'(valid_tri), 0);
    check("mid_rst_busy", 64'(busy), 0);
    check("mid_rst_ready", 64'(in_ready), 1);
    check("mid_rst_cull", 64'(cull_count), 0);
    repeat (2) @(posedge clk_in);
    @(negedge clk_in) rst_in = 1'b0;
    repeat (500) @(negedge clk_in);
    check("mid_rst_quiet", 64'(busy), 0);

    // Reference triangle and latency
    issue(base, 0, 1, base_e);
    wait_valid(edges);
    check("latency", 64'(edges), 64'(LAT));
    finish_tri("base");

    // Winding reversed
    swp = base;
    swp[1] = base[2];
    swp[2] = base[1];
    issue(swp, 0, 0, none);
    finish_tri("swap");

    // Output stall, then a single transfer of a last triangle
    out_ready = 1'b0;
    issue(base, 1, 1, base_e);
    wait_valid(edges);
    check("stall_latency", 64'(edges), 64'(LAT));
    repeat (50) begin
      @(negedge clk_in);
      check("stall_in_ready", 64'(in_ready), 0);
    end
    @(posedge clk_in);
    #1 out_ready = 1'b1;
    @(posedge clk_in); @(negedge clk_in);
    check("stall_done_pulse", 64'(obj_done), 1);
    check("stall_valid_drop", 64'(valid_tri), 0);
    @(posedge clk_in); @(negedge clk_in);
    check("stall_done_single", 64'(obj_done), 0);
    finish_tri("stall");

    // Quotient saturation
    sat = base;
    sat[0][0] = 32'h7FFF_0000; sat[0][1] = 0; sat[0][2] = 32'h0000_8001;
    sat[1][0] = 0; sat[1][1] = 0;      sat[1][2] = q16(2);
    sat[2][0] = 0; sat[2][1] = q16(1); sat[2][2] = q16(2);
    model(sat, sat_e, n_, b_);
    sat_e[2][0] = 32'h00B4_0000 + 32'h3FFF_FFFF;
    issue(sat, 0, 1, sat_e);
    finish_tri("sat");

    // Randomized triangles with random output backpressure
    rand_rdy = 1;
    for (int k = 0; k < 15; k++) begin
      for (int v = 0; v < 3; v++) begin
        rt[v][0] = 32'($urandom_range(0, 32'h0008_0000)) - 32'h0004_0000;
        rt[v][1] = 32'($urandom_range(0, 32'h0008_0000)) - 32'h0004_0000;
        if ($urandom_range(0, 9) == 0) rt[v][2] = 32'($urandom_range(0, 32'h0000_8000));
        else rt[v][2] = 32'($urandom_range(32'h0000_8001, 32'h0008_0000));
      end
      issue(rt, ($urandom_range(0, 2) == 0), 0, none);
      finish_tri("rand");
    end
    rand_rdy = 0;
    #2 out_ready = 1'b1;

    repeat (5) @(negedge clk_in);
    check("obj_done_count", 64'(seen_done), 64'(exp_done));
    check("queue_drained", 64'(exp_q.size()), 0);
    check("final_cull", 64'(cull_count), 64'(exp_cull));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
